// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned AW_DEF = 12;
  localparam int unsigned DW     = 32;
  localparam int unsigned BEW    = 4;

  localparam logic [31:0] IM_BASE_DEF = 32'h0000_3000;
  localparam logic [31:0] DM_BASE_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Access fields captured when a request wins arbitration.
  typedef struct packed {
    logic           port;
    logic           we;
    logic           err;
    logic [DW-1:0]  wdata;
    logic [BEW-1:0] be;
  } access_t;

endpackage

// File: rtl/mem_port_arbiter_addr_check.sv
// Byte address to word index conversion with alignment and range check.
module mem_port_arbiter_addr_check
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic [31:0]   i_addr,
  input  logic [31:0]   i_base,
  output logic [AW-1:0] o_idx,
  output logic          o_err
);

  // Word offset from the region base, wrapping modulo 2^32.
  logic [31:2] w_off;

  assign w_off = 30'((i_addr - i_base) >> 2);
  assign o_idx = w_off[AW+1:2];
  assign o_err = (i_addr[1:0] != 2'b00) || (w_off[31:AW+2] != '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous word memory between fetch and data ports.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter logic [31:0] IM_BASE = IM_BASE_DEF,
  parameter logic [31:0] DM_BASE = DM_BASE_DEF,
  parameter int unsigned AW      = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic [31:0]   p0_addr,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [31:0]   p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [31:0]   p1_addr,
  input  logic [31:0]   p1_wdata,
  input  logic [3:0]    p1_be,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [31:0]   p1_rdata,
  output logic          p1_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [31:0]   mem_rdata
);

  state_t        r_state, w_state_nxt;
  access_t       r_acc, w_acc_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic          r_last, w_last_nxt;

  logic [AW-1:0] w_idx0, w_idx1;
  logic          w_err0, w_err1;
  logic          w_win1;
  logic          w_access, w_resp, w_rd_ok;

  mem_port_arbiter_addr_check #(.AW(AW)) u_chk0 (
    .i_addr (p0_addr),
    .i_base (IM_BASE),
    .o_idx  (w_idx0),
    .o_err  (w_err0)
  );

  mem_port_arbiter_addr_check #(.AW(AW)) u_chk1 (
    .i_addr (p1_addr),
    .i_base (DM_BASE),
    .o_idx  (w_idx1),
    .o_err  (w_err1)
  );

  // Port 1 wins when alone, or under contention when port 0 went last.
  assign w_win1 = p1_req && (!p0_req || !r_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_addr  <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_addr  <= w_addr_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_addr_nxt  = r_addr;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (p0_req || p1_req) begin
          w_acc_nxt.port  = w_win1;
          w_acc_nxt.we    = w_win1 && p1_we;
          w_acc_nxt.err   = w_win1 ? w_err1 : w_err0;
          w_acc_nxt.wdata = w_win1 ? p1_wdata : 32'h0;
          w_acc_nxt.be    = w_win1 ? p1_be : 4'h0;
          w_addr_nxt      = w_win1 ? w_idx1 : w_idx0;
          w_last_nxt      = w_win1;
          w_state_nxt     = ACCESS;
        end
      end
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_access = (r_state == ACCESS);
  assign w_resp   = (r_state == RESP);
  assign w_rd_ok  = w_resp && !r_acc.we && !r_acc.err;

  assign p0_gnt    = w_access && !r_acc.port;
  assign p1_gnt    = w_access && r_acc.port;
  assign mem_en    = w_access && !r_acc.err;
  assign mem_we    = w_access && r_acc.we && !r_acc.err;
  assign mem_addr  = w_access ? r_addr : '0;
  assign mem_wdata = w_access ? r_acc.wdata : 32'h0;
  assign mem_be    = (w_access && r_acc.we) ? r_acc.be : 4'h0;

  assign p0_rvalid = w_resp && !r_acc.port;
  assign p1_rvalid = w_resp && r_acc.port;
  assign p0_err    = w_resp && !r_acc.port && r_acc.err;
  assign p1_err    = w_resp && r_acc.port && r_acc.err;
  // Read data is the only combinational path from the memory.
  assign p0_rdata  = (w_rd_ok && !r_acc.port) ? mem_rdata : 32'h0;
  assign p1_rdata  = (w_rd_ok && r_acc.port) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam logic [31:0] IMB = 32'h0000_3000;
  localparam logic [31:0] DMB = 32'h0000_0000;

  logic        clk, reset;
  logic        p0_req, p0_gnt, p0_rvalid, p0_err;
  logic [31:0] p0_addr, p0_rdata;
  logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [3:0]  p1_be;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_be(p1_be), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .p1_err(p1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [11:0] i);
    if (i == 12'd2) return 32'hDEAD_BEEF;
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Memory macro model: one-cycle read latency, junk on the bus when not reading.
  logic [31:0] ram [4096];
  bit          wr_flag [4096];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      ram[mem_addr]     <= merge(wr_flag[mem_addr] ? ram[mem_addr] : init_val(mem_addr),
                                 mem_wdata, mem_be);
      wr_flag[mem_addr] <= 1'b1;
    end
    mem_rdata <= (mem_en && !mem_we) ?
                 (wr_flag[mem_addr] ? ram[mem_addr] : init_val(mem_addr)) : $urandom;
  end

  typedef struct {
    logic        v;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  req_t        pend [2];
  req_t        cur;
  int          cur_port, last, phase, cyc;
  logic        cur_err;
  logic [11:0] cur_idx;
  logic [31:0] ref_mem [4096];
  int          n_total, n_bad;
  int          glog[$];
  int          gcyc[$];
  bit          gen_en, contend;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gen_addr(input logic [31:0] base);
    int k;
    logic [31:0] a;
    k = $urandom_range(0, 9);
    a = base + 32'($urandom_range(0, 15)) * 4;
    if (k == 0)      a = a + 32'($urandom_range(1, 3));
    else if (k == 1) a = base - 32'($urandom_range(1, 64)) * 4;
    else if (k == 2) a = base + 32'h4000 + 32'($urandom_range(0, 64)) * 4;
    else if (k == 3) a = base + 32'h3FFC;
    return a;
  endfunction

  function automatic req_t new_req(input int port);
    req_t r;
    r.v     = 1'b1;
    r.we    = (port == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    r.addr  = gen_addr(port == 0 ? IMB : DMB);
    r.wdata = $urandom;
    r.be    = 4'($urandom_range(1, 15));
    return r;
  endfunction

  task automatic drive();
    p0_req   = pend[0].v;
    p0_addr  = pend[0].addr;
    p1_req   = pend[1].v;
    p1_we    = pend[1].we;
    p1_addr  = pend[1].addr;
    p1_wdata = pend[1].wdata;
    p1_be    = pend[1].be;
  endtask

  // Reference arbitration: lone requester wins, otherwise the port that did not go last.
  task automatic issue_if_idle();
    logic [31:0] base, off;
    if (phase == 0 && (pend[0].v || pend[1].v)) begin
      if (pend[0].v && pend[1].v) cur_port = 1 - last;
      else                        cur_port = pend[1].v ? 1 : 0;
      cur     = pend[cur_port];
      base    = (cur_port == 0) ? IMB : DMB;
      off     = cur.addr - base;
      cur_err = (cur.addr % 4 != 0) || (off >= 32'h4000);
      cur_idx = 12'(off / 4);
      last    = cur_port;
      phase   = 1;
    end
  endtask

  task automatic step();
    int ph;
    logic [31:0] exp_d, got_d, oth_d;
    logic        got_e;
    @(negedge clk);
    cyc++;
    ph = phase;
    if (ph == 1) begin
      chk("gnt0", 32'(p0_gnt), 32'(cur_port == 0));
      chk("gnt1", 32'(p1_gnt), 32'(cur_port == 1));
      chk("mem_en", 32'(mem_en), 32'(!cur_err));
      chk("mem_we", 32'(mem_we), 32'(cur.we && !cur_err));
      if (!cur_err) begin
        chk("mem_addr", 32'(mem_addr), 32'(cur_idx));
        chk("mem_be", 32'(mem_be), cur.we ? 32'(cur.be) : 32'h0);
        if (cur.we) begin
          chk("mem_wdata", mem_wdata, cur.wdata);
          ref_mem[cur_idx] = merge(ref_mem[cur_idx], cur.wdata, cur.be);
        end
      end
      glog.push_back(cur_port);
      gcyc.push_back(cyc);
      pend[cur_port].v = 1'b0;
      phase = 2;
    end else if (ph == 2) begin
      chk("rvalid0", 32'(p0_rvalid), 32'(cur_port == 0));
      chk("rvalid1", 32'(p1_rvalid), 32'(cur_port == 1));
      exp_d = (!cur.we && !cur_err) ? ref_mem[cur_idx] : 32'h0;
      got_d = (cur_port == 0) ? p0_rdata : p1_rdata;
      oth_d = (cur_port == 0) ? p1_rdata : p0_rdata;
      got_e = (cur_port == 0) ? p0_err : p1_err;
      chk("rdata", got_d, exp_d);
      chk("rdata_other", oth_d, 32'h0);
      chk("err", 32'(got_e), 32'(cur_err));
      last_rdata = got_d;
      last_err   = got_e;
      phase = 0;
    end else begin
      chk("idle_quiet", 32'({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_en}), 32'h0);
    end
    for (int p = 0; p < 2; p++)
      if (!pend[p].v && (contend || (gen_en && $urandom_range(0, 2) == 0)))
        pend[p] = new_req(p);
    drive();
    if (ph == 0) issue_if_idle();
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (phase == 0 && !pend[0].v && !pend[1].v) done = 1'b1;
      else step();
    end
    if (!done) chk("timeout", 32'h1, 32'h0);
  endtask

  task automatic do_req(input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    pend[port] = '{1'b1, we, addr, wdata, be};
    wait_done();
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err, mem_en, mem_we}),
        32'h0);
    chk({tag, "_bus"}, 32'(mem_addr) | mem_wdata | 32'(mem_be) | p0_rdata | p1_rdata,
        32'h0);
  endtask

  initial begin
    n_total = 0; n_bad = 0; cyc = 0; phase = 0; last = 1;
    gen_en = 1'b0; contend = 1'b0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    pend[0] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
    pend[1] = pend[0];
    drive();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outs");

    // Both ports requesting continuously from reset release.
    contend = 1'b1;
    pend[0] = new_req(0);
    pend[1] = new_req(1);
    drive();
    reset = 1'b1;
    issue_if_idle();
    for (int k = 0; k < 40 && glog.size() < 4; k++) step();
    contend = 1'b0;
    wait_done();
    chk("cont_count", 32'(glog.size() >= 4), 32'h1);
    if (glog.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("cont_order", 32'(glog[i]), 32'(i % 2));
      for (int i = 0; i < 3; i++) chk("cont_spacing", 32'(gcyc[i+1] - gcyc[i]), 32'd3);
    end

    do_req(0, 1'b0, 32'h0000_3008, 32'h0, 4'h0);
    chk("fetch_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("fetch_err", 32'(last_err), 32'h0);
    do_req(1, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0011);
    chk("wr_ack_rdata", last_rdata, 32'h0);
    do_req(1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    chk("wr_readback", 32'(last_rdata[15:0]), 32'h5678);
    do_req(1, 1'b0, 32'h0000_0006, 32'h0, 4'h0);
    chk("err_misalign", 32'(last_err), 32'h1);
    do_req(0, 1'b0, 32'h0000_2FFC, 32'h0, 4'h0);
    chk("err_below", 32'(last_err), 32'h1);
    do_req(1, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
    chk("err_above", 32'(last_err), 32'h1);

    gen_en = 1'b1;
    repeat (1500) step();
    gen_en = 1'b0;
    wait_done();

    // Abort a fetch during its access cycle; port 0 went last, so reset alone makes it win again.
    pend[0] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'h0};
    for (int k = 0; k < 10 && phase != 1; k++) step();
    @(negedge clk);
    chk("pre_rst_gnt", 32'(p0_gnt), 32'h1);
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    pend[0].v = 1'b0;
    drive();
    phase = 0;
    last  = 1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'h0);
    end
    glog.delete();
    pend[0] = new_req(0);
    pend[1] = new_req(1);
    drive();
    reset = 1'b1;
    issue_if_idle();
    wait_done();
    chk("post_rst_count", 32'(glog.size() >= 1), 32'h1);
    if (glog.size() >= 1) chk("post_rst_first", 32'(glog[0]), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
